display_sr_receiver: RTL
========================

DISPLAY_SR_RECEIVER -- requirements
Module: display_sr_receiver

Interface
REQ-001 SHALL have parameter FRAME_BITS, default 24; bits per display frame (6 BCD digits x 4).
REQ-002 SHALL have parameter SYNC_STAGES, default 2; synchronizer depth on each serial input.
REQ-003 SHALL have port clk  input  1  single system clock; all state on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port serial_in  input  1  serial data from the display transmitter, asynchronous to clk.
REQ-006 SHALL have port sr_clk_in  input  1  shift clock from the transmitter; data is valid at its rising edge.
REQ-007 SHALL have port latch_in  input  1  frame latch from the transmitter; a rising edge ends the frame.
REQ-008 SHALL have ports hours_msd, hours_lsd, minutes_msd, minutes_lsd, seconds_msd, seconds_lsd  output  4 each  last accepted frame, BCD.
REQ-009 SHALL have port frame_valid  output  1  one-clk pulse when a good frame is accepted.
REQ-010 SHALL have port frame_error  output  1  one-clk pulse when a frame is rejected.
REQ-011 SHALL have port busy  output  1  high while a frame is being shifted in (state SHIFT).

Function
REQ-012 SHALL pass serial_in, sr_clk_in and latch_in through SYNC_STAGES flip-flops each, all in the same pipeline so that they stay aligned.
REQ-013 SHALL detect a rising edge on a synchronized input as: previous synchronized value 0, current value 1.
REQ-014 SHALL, on an sr_clk rising edge, shift the synchronized serial bit into a FRAME_BITS shift register, MSB first (first bit received = hours_msd[3]; last = seconds_lsd[0]).
REQ-015 SHALL count received bits in a counter that saturates at FRAME_BITS+1 and never wraps.
REQ-016 SHALL implement FSM IDLE -> SHIFT on the first sr_clk edge; SHIFT -> CHECK on a latch edge; CHECK -> IDLE after one cycle.
REQ-017 SHALL, in IDLE, treat a latch edge with zero bits received as a rejected frame (frame_error pulse).
REQ-018 SHALL, in CHECK, accept the frame only if bit count == FRAME_BITS and all six nibbles are <= 9.
REQ-019 SHALL, on accept, update all six digit outputs in the same cycle and pulse frame_valid; the latency from the raw latch_in rise to frame_valid is SYNC_STAGES+2 clk cycles.
REQ-020 SHALL, on reject, hold all digit outputs unchanged, pulse frame_error, and never assert it together with frame_valid.
REQ-021 SHALL clear the bit counter and shift register on entry to IDLE.
REQ-022 SHALL give priority to the latch edge over an sr_clk edge detected in the same cycle; that bit is discarded.
REQ-023 SHALL operate correctly when sr_clk_in high and low phases are each >= SYNC_STAGES+1 clk cycles; faster input gives undefined data but SHALL NOT lock up the FSM.
REQ-024 SHALL accept back-to-back frames: an sr_clk edge one cycle after CHECK begins the next frame.

Reset
REQ-025 SHALL, while reset is high, force state IDLE, synchronizers 0, counter 0, shift register 0, all digit outputs 4'h0, and frame_valid, frame_error and busy 0.
REQ-026 SHALL discard any partially received frame on reset, with no valid or error pulse generated.

Structure
REQ-027 SHALL take FRAME_BITS, DIGIT_W=4, BCD_MAX=9 and the FSM state encoding from shared package clock_pkg.
REQ-028 SHALL instantiate sub-module sync_edge (parameterised N-stage synchronizer + rising-edge detector, outputs level and rise) once per serial input.

Verification
REQ-029 Frame 0x123456 (24 bits), then latch -> hours 1,2; minutes 3,4; seconds 5,6; one frame_valid; frame_error stays 0.
REQ-030 20 bits followed by a latch -> frame_error pulse; outputs keep the previous frame 12:34:56.
REQ-031 30 bits followed by a latch -> frame_error pulse; counter saturated at 25; no wrap and no valid pulse.
REQ-032 Frame 0x12A456 -> frame_error pulse (nibble 0xA); outputs unchanged.
REQ-033 Reset asserted after bit 10, then released, then a full frame 0x235959 -> all digits 0 during reset, then 23:59:59 with exactly one frame_valid.
REQ-034 Two frames 0x000001 and 0x000002 back-to-back at the minimum phase width -> two frame_valid pulses, final seconds_lsd = 2.

Source files
------------

// File: rtl/clock_pkg.sv
// Shared constants, FSM encoding and BCD helper for the display shift-register receiver.
package clock_pkg;

    localparam int FRAME_BITS = 24;
    localparam int DIGIT_W    = 4;
    localparam int BCD_MAX    = 9;
    localparam int NUM_DIGITS = 6;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_CHECK = 2'b10
    } state_t;

    // A nibble is a legal BCD digit when it does not exceed BCD_MAX.
    function automatic logic is_bcd_digit(input logic [DIGIT_W-1:0] d);
        return (d <= DIGIT_W'(BCD_MAX));
    endfunction

endpackage

// File: rtl/sync_edge.sv
// N-stage synchronizer followed by a rising-edge detector on the synchronized level.
module sync_edge #(
    parameter int N = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic level,
    output logic rise
);

    logic [N-1:0] chain_r;
    logic         prev_r;

    // Synchronizer chain plus one extra flop holding the previous synchronized level.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            chain_r <= '0;
            prev_r  <= 1'b0;
        end else begin
            chain_r[0] <= d;
            for (int i = 1; i < N; i++) begin
                chain_r[i] <= chain_r[i-1];
            end
            prev_r <= chain_r[N-1];
        end
    end

    assign level = chain_r[N-1];
    assign rise  = chain_r[N-1] & ~prev_r;

endmodule

// File: rtl/display_sr_receiver.sv
// Receives a 6-digit BCD frame over a 3-wire shift/latch link and presents the last good frame.
module display_sr_receiver
    import clock_pkg::*;
#(
    parameter int FRAME_BITS  = clock_pkg::FRAME_BITS,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       serial_in,
    input  logic       sr_clk_in,
    input  logic       latch_in,
    output logic [3:0] hours_msd,
    output logic [3:0] hours_lsd,
    output logic [3:0] minutes_msd,
    output logic [3:0] minutes_lsd,
    output logic [3:0] seconds_msd,
    output logic [3:0] seconds_lsd,
    output logic       frame_valid,
    output logic       frame_error,
    output logic       busy
);

    localparam int CNT_W   = $clog2(FRAME_BITS + 2);
    localparam int CNT_MAX = FRAME_BITS + 1;

    logic                  ser_level_s;
    logic                  ser_rise_s;
    logic                  sr_level_s;
    logic                  sr_rise_s;
    logic                  latch_level_s;
    logic                  latch_rise_s;

    state_t                state_r;
    state_t                next_state_s;
    logic [FRAME_BITS-1:0] shift_r;
    logic [CNT_W-1:0]      bit_cnt_r;
    logic                  do_shift_s;
    logic                  do_clear_s;
    logic                  accept_s;
    logic                  reject_s;
    logic                  nibbles_ok_s;
    logic                  bits_ok_s;

    // All three link inputs go through identical pipelines so they stay cycle-aligned.
    sync_edge #(.N(SYNC_STAGES)) u_sync_ser (
        .clk(clk), .reset(reset), .d(serial_in), .level(ser_level_s), .rise(ser_rise_s)
    );
    sync_edge #(.N(SYNC_STAGES)) u_sync_sr (
        .clk(clk), .reset(reset), .d(sr_clk_in), .level(sr_level_s), .rise(sr_rise_s)
    );
    sync_edge #(.N(SYNC_STAGES)) u_sync_latch (
        .clk(clk), .reset(reset), .d(latch_in), .level(latch_level_s), .rise(latch_rise_s)
    );

    // Frame is acceptable only with an exact bit count and every nibble a legal BCD digit.
    always_comb begin
        nibbles_ok_s = 1'b1;
        for (int k = 0; k < FRAME_BITS / DIGIT_W; k++) begin
            if (!is_bcd_digit(shift_r[k*DIGIT_W +: DIGIT_W])) begin
                nibbles_ok_s = 1'b0;
            end else begin
                nibbles_ok_s = nibbles_ok_s;
            end
        end
        bits_ok_s = nibbles_ok_s && (bit_cnt_r == CNT_W'(FRAME_BITS));
    end

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state and datapath controls; a latch edge always wins over a same-cycle shift edge.
    always_comb begin
        next_state_s = state_r;
        do_shift_s   = 1'b0;
        do_clear_s   = 1'b0;
        accept_s     = 1'b0;
        reject_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (latch_rise_s) begin
                    reject_s = 1'b1;
                end else if (sr_rise_s) begin
                    next_state_s = ST_SHIFT;
                    do_shift_s   = 1'b1;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (latch_rise_s) begin
                    next_state_s = ST_CHECK;
                end else if (sr_rise_s) begin
                    do_shift_s = 1'b1;
                end else begin
                    next_state_s = ST_SHIFT;
                end
            end
            ST_CHECK: begin
                next_state_s = ST_IDLE;
                do_clear_s   = 1'b1;
                if (bits_ok_s) begin
                    accept_s = 1'b1;
                end else begin
                    reject_s = 1'b1;
                end
            end
            default: begin
                next_state_s = ST_IDLE;
                do_clear_s   = 1'b1;
            end
        endcase
    end

    // Shift register and saturating bit counter; both cleared when returning to idle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shift_r   <= '0;
            bit_cnt_r <= '0;
        end else if (do_clear_s) begin
            shift_r   <= '0;
            bit_cnt_r <= '0;
        end else if (do_shift_s) begin
            shift_r <= {shift_r[FRAME_BITS-2:0], ser_level_s};
            if (bit_cnt_r != CNT_W'(CNT_MAX)) begin
                bit_cnt_r <= bit_cnt_r + CNT_W'(1);
            end
        end
    end

    // Registered outputs: digits load together on accept, status pulses last one cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hours_msd   <= 4'h0;
            hours_lsd   <= 4'h0;
            minutes_msd <= 4'h0;
            minutes_lsd <= 4'h0;
            seconds_msd <= 4'h0;
            seconds_lsd <= 4'h0;
            frame_valid <= 1'b0;
            frame_error <= 1'b0;
            busy        <= 1'b0;
        end else begin
            frame_valid <= accept_s;
            frame_error <= reject_s;
            busy        <= (next_state_s == ST_SHIFT);
            if (accept_s) begin
                hours_msd   <= shift_r[FRAME_BITS-1  -: 4];
                hours_lsd   <= shift_r[FRAME_BITS-5  -: 4];
                minutes_msd <= shift_r[FRAME_BITS-9  -: 4];
                minutes_lsd <= shift_r[FRAME_BITS-13 -: 4];
                seconds_msd <= shift_r[FRAME_BITS-17 -: 4];
                seconds_lsd <= shift_r[FRAME_BITS-21 -: 4];
            end
        end
    end

endmodule
